// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the serial lookahead adder and accumulator
package adder_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} accum_state_t;
  localparam int ADDER_GROUP_WIDTH = 4;
endpackage

// File: rtl/adder_xxbit_ahead_serial.sv
// adder_xxbit_ahead_serial: 4-bit carry-lookahead groups chained by a ripple carry between groups
module adder_xxbit_ahead_serial
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);
  localparam int NG = DATA_WIDTH / ADDER_GROUP_WIDTH;
  logic [DATA_WIDTH-1:0] g, p, ci;
  logic [NG:0] c;
  assign g = i_num_a & i_num_b;
  assign p = i_num_a ^ i_num_b;
  assign c[0] = i_cry;
  genvar k;
  for (k = 0; k < NG; k++) begin : g_grp
    localparam int L = k * ADDER_GROUP_WIDTH;
    // every carry inside a group is a flat function of the group's carry-in
    assign ci[L]   = c[k];
    assign ci[L+1] = g[L] | (p[L] & c[k]);
    assign ci[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & c[k]);
    assign ci[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                   | (p[L+2] & p[L+1] & p[L] & c[k]);
    assign c[k+1]  = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                   | (p[L+3] & p[L+2] & p[L+1] & g[L])
                   | (p[L+3] & p[L+2] & p[L+1] & p[L] & c[k]);
  end
  assign o_res = p ^ ci;
  assign o_cry = c[NG];
endmodule

// File: rtl/adder_xxbit_accum.sv
// adder_xxbit_accum: packet accumulator closing the feedback loop around the serial lookahead adder
module adder_xxbit_accum
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_num,
  input  logic                   i_sub,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_sum,
  output logic                   o_ovf,
  output logic [COUNT_WIDTH-1:0] o_cnt
);
  if (DATA_WIDTH % ADDER_GROUP_WIDTH != 0 || DATA_WIDTH < ADDER_GROUP_WIDTH) begin : g_bad_width
    $error("adder_xxbit_accum: DATA_WIDTH must be a nonzero multiple of 4");
  end
  accum_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d, num_b, res;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, cry, acc;
  adder_xxbit_ahead_serial #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .i_num_a(sum_q),
    .i_num_b(num_b),
    .i_cry  (i_sub),
    .o_res  (res),
    .o_cry  (cry)
  );
  assign o_ready = state_q != DONE;
  assign o_valid = state_q == DONE;
  assign o_sum   = sum_q;
  assign o_ovf   = ovf_q;
  assign o_cnt   = cnt_q;
  // subtraction is a + ~b + 1, so a missing carry-out means a borrow
  always_comb begin
    acc = i_valid && o_ready;
    num_b = i_sub ? ~i_num : i_num;
    state_d = state_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (i_clr || (o_valid && i_ready)) begin
      state_d = IDLE;
      sum_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (acc) begin
      state_d = i_last ? DONE : ACC;
      sum_d = res;
      ovf_d = ovf_q | (i_sub ? ~cry : cry);
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sum_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_adder_xxbit_accum.sv
// tb_adder_xxbit_accum: scoreboard bench with an arithmetic reference model for the accumulator
module tb_adder_xxbit_accum;
  typedef struct {
    int sum;
    int ovf;
    int cnt;
  } exp_t;

  logic       clk = 0;
  logic       rst = 1, clr = 0, valid = 0, sub = 0, last = 0;
  logic [7:0] num = 0;
  logic       ready_o, valid_o, ovf_o;
  logic [7:0] sum_o;
  logic [3:0] cnt_o;
  logic       force_rdy = 1, rdy_val = 1, rnd_rdy = 1;
  logic       i_ready;
  assign i_ready = force_rdy ? rdy_val : rnd_rdy;

  int checks = 0, fails = 0;
  exp_t sb[$];
  int pk_num[$];
  int pk_sub[$];
  int m_sum, m_ovf, m_cnt;

  adder_xxbit_accum #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(valid), .o_ready(ready_o),
    .i_num(num), .i_sub(sub), .i_last(last), .o_valid(valid_o), .i_ready(i_ready),
    .o_sum(sum_o), .o_ovf(ovf_o), .o_cnt(cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rnd_rdy <= $urandom_range(0, 2) != 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !clr && valid_o && i_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_sum", int'(sum_o), e.sum);
        chk("res_ovf", int'(ovf_o), e.ovf);
        chk("res_cnt", int'(cnt_o), e.cnt);
      end
    end
  end

  task automatic model_reset();
    m_sum = 0;
    m_ovf = 0;
    m_cnt = 0;
  endtask

  task automatic model_beat(input int n, input int s);
    int r;
    r = s ? m_sum - n : m_sum + n;
    if (r < 0 || r > 255) m_ovf = 1;
    m_sum = (r + 256) % 256;
    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
  endtask

  task automatic send(input int n, input int s, input int l);
    bit ok = 0;
    valid = 1;
    num = 8'(n);
    sub = s[0];
    last = l[0];
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      #1;
    end
    valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk);
      #1;
      ok = ready_o;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_pkt(input bit gaps);
    model_reset();
    for (int i = 0; i < pk_num.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pk_num[i], pk_sub[i], int'(i == pk_num.size() - 1));
      model_beat(pk_num[i], pk_sub[i]);
      chk("beat_sum", int'(sum_o), m_sum);
    end
    chk("valid_latency", int'(valid_o), 1);
    sb.push_back('{m_sum, m_ovf, m_cnt});
    pk_num.delete();
    pk_sub.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, int'(ready_o), 1);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_sum"}, int'(sum_o), 0);
    chk({tag, "_ovf"}, int'(ovf_o), 0);
    chk({tag, "_cnt"}, int'(cnt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    valid = 1;
    num = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;
    valid = 0;
    @(posedge clk);
    #1;
    check_zero("post_reset");

    pk_num = '{8'h10, 8'h20, 8'h05}; pk_sub = '{0, 0, 0};
    run_pkt(0); wait_idle();
    pk_num = '{8'hF0, 8'h20, 8'h05}; pk_sub = '{0, 0, 1};
    run_pkt(0); wait_idle();
    pk_num = '{8'h01}; pk_sub = '{1};
    run_pkt(0); wait_idle();
    pk_num = '{8'h00, 8'h00}; pk_sub = '{1, 1};
    run_pkt(0); wait_idle();

    rdy_val = 0;
    pk_num = '{8'h33, 8'h44}; pk_sub = '{0, 0};
    run_pkt(0);
    valid = 1;
    num = 8'h99;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", int'(ready_o), 0);
      chk("bp_valid", int'(valid_o), 1);
      chk("bp_sum", int'(sum_o), 8'h77);
      chk("bp_ovf", int'(ovf_o), 0);
      chk("bp_cnt", int'(cnt_o), 2);
    end
    rdy_val = 1;
    @(posedge clk);
    #1;
    valid = 0;
    check_zero("bp_release");

    model_reset();
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    chk("clr_pre_cnt", int'(cnt_o), 2);
    clr = 1;
    valid = 1;
    num = 8'h40;
    @(posedge clk);
    #1;
    clr = 0;
    valid = 0;
    check_zero("clear");
    pk_num = '{8'h07}; pk_sub = '{0};
    run_pkt(0); wait_idle();

    for (int i = 0; i < 17; i++) begin
      pk_num.push_back(1);
      pk_sub.push_back(0);
    end
    run_pkt(0); wait_idle();

    force_rdy = 0;
    for (int p = 0; p < 30; p++) begin
      int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        pk_num.push_back(int'($urandom_range(0, 255)));
        pk_sub.push_back(int'($urandom_range(0, 1)));
      end
      run_pkt(1);
      wait_idle();
    end
    force_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/adder_xxbit_accum.md
# adder_xxbit_accum

Streaming accumulator that sits directly downstream of `adder_xxbit_ahead_serial` and closes its feedback loop. It accepts a packet of operands over a valid/ready handshake. For each operand it adds it to, or subtracts it from, a registered running sum through one instance of the serial ahead-carry adder. After the last beat of the packet it presents the final sum, a sticky overflow/borrow flag and a term count on an output handshake.

## Interface

Parameters:
- `DATA_WIDTH`, 8: operand and sum width; must be a multiple of 4, minimum 4.
- `COUNT_WIDTH`, 4: width of the term counter.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: synchronous reset, active-high.
- `i_clr` input 1: synchronous packet abort/clear, active-high.
- `i_valid` input 1: input beat valid.
- `o_ready` output 1: block can accept a beat.
- `i_num` input `DATA_WIDTH`: operand.
- `i_sub` input 1: 1 = subtract `i_num`, 0 = add.
- `i_last` input 1: beat is the last of the packet.
- `o_valid` output 1: result valid.
- `i_ready` input 1: downstream accepts result.
- `o_sum` output `DATA_WIDTH`: accumulated sum, modulo 2^`DATA_WIDTH`.
- `o_ovf` output 1: sticky flag; set on any add carry-out or subtract borrow within the packet.
- `o_cnt` output `COUNT_WIDTH`: number of beats accepted in the packet, saturating.

## Operation

- FSM states:
  - `IDLE`: accumulator is 0, no beat accepted yet.
  - `ACC`: at least one beat accepted.
  - `DONE`: result held.
- Outputs per state:
  - `o_ready` = 1 in `IDLE` and `ACC`, 0 in `DONE`.
  - `o_valid` = 1 only in `DONE`.
- Beat accept = `i_valid && o_ready`. On accept:
  - Adder inputs: `i_num_a` = accumulator, `i_num_b` = `i_sub ? ~i_num : i_num`, `i_cry` = `i_sub`.
  - Accumulator <= adder `o_res`.
  - `o_ovf` <= `o_ovf | (i_sub ? ~o_cry : o_cry)`.
  - `o_cnt` <= `o_cnt + 1`, holding at all-ones once saturated.
  - Next state is `DONE` if `i_last`, else `ACC`.
- Without accept, the accumulator, `o_ovf` and `o_cnt` hold.
- `DONE` with `i_ready` = 1: return to `IDLE`; clear accumulator, `o_ovf` and `o_cnt` to 0.
- `DONE` with `i_ready` = 0: hold all outputs stable.
- Inputs are ignored while `o_ready` = 0.
- `i_clr` = 1 in any state: next state is `IDLE` with everything zeroed. `i_clr` has priority over a simultaneous accept or result handshake; that beat or result is discarded.
- `i_rst` has priority over `i_clr`. Reset values:
  - state `IDLE`
  - `o_ready` 1
  - `o_valid` 0
  - `o_sum` 0
  - `o_ovf` 0
  - `o_cnt` 0
- Wrap-around:
  - The sum wraps modulo 2^`DATA_WIDTH`; `o_ovf` records that a wrap occurred.
  - Subtracting 0 produces no borrow, since carry-out = 1.
- Single-beat packet (`i_last` on the first beat) is legal: `IDLE` -> `DONE`.

## Timing

- All outputs are registered. `o_sum` reflects an accepted beat in the next cycle.
- `o_valid` rises the cycle after the `i_last` beat is accepted.
- Minimum packet turnaround is N+1 cycles for an N-beat packet: `o_ready` returns the cycle after the result handshake.
- There is no bypass of the result into a new packet. A beat presented in the `DONE` cycle is not accepted.
- Back-to-back accepts are sustained at one beat per cycle in `IDLE`/`ACC`.
- Critical path: accumulator register -> `DATA_WIDTH`/4 rippled 4-bit lookahead groups -> accumulator register.

## Structure

- Shared package `adder_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACC, DONE} accum_state_t`.
  - Localparam `ADDER_GROUP_WIDTH = 4`.
- Sub-module: one instance of `adder_xxbit_ahead_serial` with `DATA_WIDTH` passed through.
- All other logic is in this module:
  - FSM
  - operand inversion mux
  - accumulator, flag and counter registers
- Elaboration-time check: `DATA_WIDTH % 4 == 0`.

## Test plan

All scenarios use `DATA_WIDTH` = 8 and `COUNT_WIDTH` = 4.

- Reset:
  - Stimulus: hold `i_rst` 2 cycles with `i_valid` = 1.
  - Required: `o_ready`=1, `o_valid`=0, `o_sum`=0x00, `o_ovf`=0, `o_cnt`=0, and no beat accepted.
- Add packet:
  - Stimulus: 0x10, 0x20, 0x05 (last), `i_sub`=0, back-to-back.
  - Required: `o_valid` in cycle 4 with `o_sum`=0x35, `o_ovf`=0, `o_cnt`=3.
- Overflow and borrow:
  - Stimulus: add 0xF0, add 0x20 (wraps to 0x10, `o_ovf`=1), then sub 0x05 (last).
  - Required: `o_sum`=0x0B, `o_ovf`=1.
  - Separately: sub 0x01 from 0.
  - Required: `o_sum`=0xFF, `o_ovf`=1, `o_cnt`=1.
- Output backpressure:
  - Stimulus: `i_ready`=0 for 5 cycles in `DONE` while `i_valid`=1 with new data.
  - Required: `o_sum`, `o_ovf`, `o_cnt` stable and `o_ready`=0. When `i_ready` rises: `IDLE` next cycle, fields zeroed.
- Clear mid-packet:
  - Stimulus: two beats accepted, then `i_clr`=1 together with a valid beat.
  - Required: beat discarded, state `IDLE`, all zero. A following single beat 0x07 (last) gives `o_sum`=0x07, `o_cnt`=1.
- Counter saturation:
  - Stimulus: 17 beats of 0x01.
  - Required: `o_cnt`=15, `o_sum`=0x11, `o_ovf`=0.
